irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Interrupt controller in front of the CP0 block. It collects N_SRC peripheral interrupt lines into one request.
- Per source: rising-edge capture into a sticky pending register, then masking by a software-written mask register.
- Fixed-priority choice of one source; drives the CP0 external interrupt input (ir_in) through a request/taken/ERET handshake.
- Reports the serviced source index as a cause code, which the exception handler reads.

Parameters:
- N_SRC, 8, number of interrupt source lines.
- ID_W, 3, width of cause index; must satisfy 2**ID_W >= N_SRC.
- CNT_W, 16, width of the saturating serviced-interrupt counter.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  synchronous reset, active-high.
- irq_src  input  N_SRC  raw interrupt lines from peripherals; level signals, asynchronous to software.
- mask_we  input  1  mask register write enable (EXE stage).
- mask_wdata  input  N_SRC  new mask value; bit = 1 enables that source.
- mask  output  N_SRC  current mask register.
- pending  output  N_SRC  current sticky pending register.
- ir_out  output  1  interrupt request to CP0 ir_in.
- ir_taken  input  1  CP0 accepted the interrupt (its interrupt jump fired this cycle).
- eret  input  1  ERET executed; handler finished.
- cause_id  output  ID_W  index of the requested or serviced source.
- busy  output  1  high in the REQ and SERVICE states.
- irq_count  output  CNT_W  number of interrupts taken, saturating.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - mask = 0, pending = 0, prev = 0, state = IDLE.
  - ir_out = 0, cause_id = 0, busy = 0, irq_count = 0.
  - Reset mid-REQ or mid-SERVICE aborts with no ERET required.
  - Because prev resets to 0, a line held high through reset is captured as pending on the first edge after reset.
- Edge capture:
  - prev <= irq_src every cycle.
  - rise = irq_src & ~prev.
  - pending[i] <= pending[i] | rise[i], except when cleared by take (below).
  - If a set and a clear hit the same bit in one cycle, set wins.
- Mask register:
  - mask <= mask_wdata when mask_we = 1.
  - Masking never clears pending.
- Selection:
  - elig = pending & mask.
  - Winner = lowest set index in elig (index 0 is highest priority).
- FSM:
  - IDLE:
    - ir_out = 0.
    - If elig != 0: cause_id <= winner, go to REQ.
  - REQ:
    - ir_out = 1, held as a level until resolved.
    - If ir_taken = 1: clear pending[cause_id], go to SERVICE, and irq_count += 1 unless it is all ones.
    - Else if mask_we = 1 and mask_wdata[cause_id] = 0: withdraw to IDLE, ir_out = 0 next cycle, pending stays set.
    - ir_taken and a withdraw in the same cycle: taken wins.
    - cause_id is frozen in REQ; a higher-priority arrival does not preempt.
  - SERVICE:
    - ir_out = 0, cause_id holds.
    - New edges keep accumulating in pending.
    - On eret = 1: go to IDLE.
- Other rules:
  - eret in IDLE or REQ is ignored.
  - ir_taken in IDLE or SERVICE is ignored.
  - busy = (state != IDLE).
- Latency:
  - Rise on irq_src before edge k: pending set at edge k, REQ entered at edge k+1, ir_out high from edge k+1.
  - After eret (edge m), IDLE is entered at m.
  - A still-eligible source re-enters REQ at m+1. Back-to-back interrupts therefore have one IDLE cycle between them.

Test Plan:
- Reset, then mask = 8'h04, pulse irq_src[2] high 1 cycle -> pending = 8'h04 next edge, ir_out = 1 one edge later, cause_id = 2. ir_taken -> pending = 0, busy = 1, irq_count = 1. eret -> IDLE, ir_out stays 0.
- mask = 8'hFF, irq_src bits 5 and 1 rise in the same cycle -> cause_id = 1 first. After taken and eret, REQ for cause_id = 5 after one IDLE cycle. irq_count = 2.
- mask = 0, irq_src[3] rises -> pending = 8'h08, ir_out stays 0. Then mask_we with 8'h08 -> ir_out = 1 two edges later, cause_id = 3.
- In REQ for cause_id = 3, write mask = 0 without ir_taken -> ir_out drops next edge, pending[3] still 1. Repeat with ir_taken in the same cycle -> SERVICE entered, pending[3] cleared.
- In SERVICE, irq_src[0] rises -> no ir_out until eret, then REQ with cause_id = 0. Same-cycle set and clear of pending[cause_id] -> bit remains 1.
- irq_src[7] held high through rst -> pending[7] = 1 on the first post-reset edge. Assert rst in SERVICE -> all outputs 0 at once. Force irq_count to saturate at 16'hFFFF -> stays there.

Source files
------------

// File: rtl/irq_arbiter.sv
// Interrupt arbiter in front of CP0: captures rising edges into sticky pending bits, masks them,
// picks the lowest eligible index and drives ir_in through a request/taken/ERET handshake.
module irq_arbiter #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             ir_out,
  input  logic             ir_taken,
  input  logic             eret,
  output logic [ID_W-1:0]  cause_id,
  output logic             busy,
  output logic [CNT_W-1:0] irq_count
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           r_state, w_state_d;
  logic [N_SRC-1:0] r_mask, r_pending, r_prev;
  logic [ID_W-1:0]  r_cause_id, w_cause_id_d;
  logic [CNT_W-1:0] r_count;

  logic [N_SRC-1:0] w_rise, w_elig, w_clr, w_pending_d;
  logic [ID_W-1:0]  w_winner;
  logic             w_take, w_withdraw;

  assign w_rise = irq_src & ~r_prev;
  assign w_elig = r_pending & r_mask;

  // Descending scan so the lowest set index is the last one assigned.
  always_comb begin
    w_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = ID_W'(i);
    end
  end

  assign w_take     = (r_state == StReq) && ir_taken;
  assign w_withdraw = (r_state == StReq) && !ir_taken && mask_we && !mask_wdata[r_cause_id];
  assign w_clr      = w_take ? (N_SRC'(1) << r_cause_id) : '0;
  // A new edge on the bit being cleared must survive.
  assign w_pending_d = (r_pending & ~w_clr) | w_rise;

  always_comb begin
    w_state_d    = r_state;
    w_cause_id_d = r_cause_id;
    unique case (r_state)
      StIdle: begin
        if (w_elig != '0) begin
          w_state_d    = StReq;
          w_cause_id_d = w_winner;
        end
      end
      StReq: begin
        if (w_take)          w_state_d = StService;
        else if (w_withdraw) w_state_d = StIdle;
      end
      StService: begin
        if (eret) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_mask     <= '0;
      r_pending  <= '0;
      r_prev     <= '0;
      r_cause_id <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pending  <= w_pending_d;
      r_prev     <= irq_src;
      r_cause_id <= w_cause_id_d;
      if (mask_we) r_mask <= mask_wdata;
      if (w_take && (r_count != '1)) r_count <= r_count + CNT_W'(1);
    end
  end

  assign mask      = r_mask;
  assign pending   = r_pending;
  assign ir_out    = (r_state == StReq);
  assign busy      = (r_state != StIdle);
  assign cause_id  = r_cause_id;
  assign irq_count = r_count;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter; a second narrow-counter instance exercises saturation.
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src, mask_wdata, mask, pending;
  logic       mask_we, ir_taken, eret, ir_out, busy;
  logic [2:0] cause_id;
  logic [15:0] irq_count;
  logic [7:0] s_mask, s_pending;
  logic       s_ir_out, s_busy;
  logic [2:0] s_cause_id, s_irq_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] e;

  always #5 clk = ~clk;

  irq_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask), .pending(pending), .ir_out(ir_out), .ir_taken(ir_taken), .eret(eret),
    .cause_id(cause_id), .busy(busy), .irq_count(irq_count)
  );

  irq_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(s_mask), .pending(s_pending), .ir_out(s_ir_out), .ir_taken(ir_taken), .eret(eret),
    .cause_id(s_cause_id), .busy(s_busy), .irq_count(s_irq_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ir_taken = 1'b0; eret = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] s);
    irq_src = s;
    tick();
    irq_src = '0;
  endtask

  task automatic take();
    ir_taken = 1'b1;
    tick();
    ir_taken = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (ir_out) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mask !== 8'h00) begin n_errors++; $display("FAIL rst_mask got %h want 00", mask); end
    n_checks++; if (pending !== 8'h00) begin n_errors++; $display("FAIL rst_pending got %h want 00", pending); end
    n_checks++; if ({ir_out, busy} !== 2'b00) begin n_errors++; $display("FAIL rst_irout_busy got %b want 00", {ir_out, busy}); end
    n_checks++; if (cause_id !== 3'd0) begin n_errors++; $display("FAIL rst_cause got %0d want 0", cause_id); end
    n_checks++; if (irq_count !== 16'd0) begin n_errors++; $display("FAIL rst_count got %0d want 0", irq_count); end
  endtask

  task automatic test_single();
    do_reset();
    write_mask(8'h04);
    exp_q.push_back(3'd2);
    pulse_src(8'h04);
    n_checks++; if (pending !== 8'h04) begin n_errors++; $display("FAIL single_pending got %h want 04", pending); end
    n_checks++; if (ir_out !== 1'b0) begin n_errors++; $display("FAIL single_early_req got %b want 0", ir_out); end
    tick();
    n_checks++; if (ir_out !== 1'b1) begin n_errors++; $display("FAIL single_req got %b want 1", ir_out); end
    e = exp_q.pop_front();
    n_checks++; if (cause_id !== e) begin n_errors++; $display("FAIL single_cause got %0d want %0d", cause_id, e); end
    take();
    n_checks++; if (pending !== 8'h00) begin n_errors++; $display("FAIL single_clr got %h want 00", pending); end
    n_checks++; if ({busy, ir_out} !== 2'b10) begin n_errors++; $display("FAIL single_svc got %b want 10", {busy, ir_out}); end
    n_checks++; if (irq_count !== 16'd1) begin n_errors++; $display("FAIL single_count got %0d want 1", irq_count); end
    do_eret();
    tick();
    n_checks++; if ({busy, ir_out} !== 2'b00) begin n_errors++; $display("FAIL single_idle got %b want 00", {busy, ir_out}); end
  endtask

  task automatic test_priority();
    do_reset();
    write_mask(8'hFF);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd5);
    pulse_src(8'h22);
    tick();
    e = exp_q.pop_front();
    n_checks++; if ({ir_out, cause_id} !== {1'b1, e}) begin n_errors++; $display("FAIL prio_first got %b/%0d want 1/%0d", ir_out, cause_id, e); end
    take();
    do_eret();
    n_checks++; if (ir_out !== 1'b0) begin n_errors++; $display("FAIL prio_gap got %b want 0", ir_out); end
    tick();
    e = exp_q.pop_front();
    n_checks++; if ({ir_out, cause_id} !== {1'b1, e}) begin n_errors++; $display("FAIL prio_second got %b/%0d want 1/%0d", ir_out, cause_id, e); end
    take();
    do_eret();
    n_checks++; if (irq_count !== 16'd2) begin n_errors++; $display("FAIL prio_count got %0d want 2", irq_count); end
  endtask

  task automatic test_mask_withdraw();
    do_reset();
    pulse_src(8'h08);
    n_checks++; if (pending !== 8'h08) begin n_errors++; $display("FAIL masked_pending got %h want 08", pending); end
    tick();
    n_checks++; if (ir_out !== 1'b0) begin n_errors++; $display("FAIL masked_req got %b want 0", ir_out); end
    exp_q.push_back(3'd3);
    write_mask(8'h08);
    n_checks++; if (ir_out !== 1'b0) begin n_errors++; $display("FAIL unmask_early got %b want 0", ir_out); end
    tick();
    e = exp_q.pop_front();
    n_checks++; if ({ir_out, cause_id} !== {1'b1, e}) begin n_errors++; $display("FAIL unmask_req got %b/%0d want 1/%0d", ir_out, cause_id, e); end
    write_mask(8'h00);
    n_checks++; if ({ir_out, busy} !== 2'b00) begin n_errors++; $display("FAIL withdraw got %b want 00", {ir_out, busy}); end
    n_checks++; if (pending[3] !== 1'b1) begin n_errors++; $display("FAIL withdraw_pending got %b want 1", pending[3]); end
    write_mask(8'h08);
    tick();
    n_checks++; if (ir_out !== 1'b1) begin n_errors++; $display("FAIL rereq got %b want 1", ir_out); end
    mask_we = 1'b1; mask_wdata = 8'h00; ir_taken = 1'b1;
    tick();
    mask_we = 1'b0; ir_taken = 1'b0;
    n_checks++; if ({busy, ir_out} !== 2'b10) begin n_errors++; $display("FAIL taken_wins got %b want 10", {busy, ir_out}); end
    n_checks++; if (pending[3] !== 1'b0) begin n_errors++; $display("FAIL taken_wins_clr got %b want 0", pending[3]); end
    do_eret();
  endtask

  task automatic test_service_accum();
    do_reset();
    write_mask(8'hFF);
    pulse_src(8'h04);
    tick();
    take();
    pulse_src(8'h01);
    n_checks++; if (pending !== 8'h01) begin n_errors++; $display("FAIL svc_pending got %h want 01", pending); end
    eret = 1'b0; tick(); tick();
    n_checks++; if ({busy, ir_out, cause_id} !== {2'b10, 3'd2}) begin n_errors++; $display("FAIL svc_hold got %b/%0d want 10/2", {busy, ir_out}, cause_id); end
    exp_q.push_back(3'd0);
    do_eret();
    n_checks++; if ({busy, ir_out} !== 2'b00) begin n_errors++; $display("FAIL svc_eret got %b want 00", {busy, ir_out}); end
    tick();
    e = exp_q.pop_front();
    n_checks++; if ({ir_out, cause_id} !== {1'b1, e}) begin n_errors++; $display("FAIL svc_next got %b/%0d want 1/%0d", ir_out, cause_id, e); end
    irq_src = 8'h01; ir_taken = 1'b1;
    tick();
    irq_src = 8'h00; ir_taken = 1'b0;
    n_checks++; if ({busy, pending[0]} !== 2'b11) begin n_errors++; $display("FAIL set_wins got %b want 11", {busy, pending[0]}); end
    exp_q.push_back(3'd0);
    do_eret();
    tick();
    e = exp_q.pop_front();
    n_checks++; if ({ir_out, cause_id} !== {1'b1, e}) begin n_errors++; $display("FAIL set_wins_req got %b/%0d want 1/%0d", ir_out, cause_id, e); end
  endtask

  task automatic test_held_and_reset();
    rst = 1'b1; irq_src = 8'h80; mask_we = 1'b0; ir_taken = 1'b0; eret = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (pending !== 8'h80) begin n_errors++; $display("FAIL held_pending got %h want 80", pending); end
    write_mask(8'hFF);
    tick();
    n_checks++; if ({ir_out, cause_id} !== {1'b1, 3'd7}) begin n_errors++; $display("FAIL held_req got %b/%0d want 1/7", ir_out, cause_id); end
    take();
    irq_src = 8'h00; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({ir_out, busy, cause_id, irq_count} !== 21'd0) begin n_errors++; $display("FAIL svc_reset got %b/%b/%0d/%0d want 0", ir_out, busy, cause_id, irq_count); end
    n_checks++; if ({mask, pending} !== 16'h0000) begin n_errors++; $display("FAIL svc_reset_regs got %h/%h want 00/00", mask, pending); end
  endtask

  task automatic test_back_to_back();
    bit found;
    do_reset();
    write_mask(8'hFF);
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(3'd4);
      pulse_src(8'h10);
      wait_req(4, found);
      n_checks++; if (!found) begin n_errors++; $display("FAIL b2b_timeout got no request want request %0d", i); end
      e = exp_q.pop_front();
      n_checks++; if (cause_id !== e) begin n_errors++; $display("FAIL b2b_cause got %0d want %0d", cause_id, e); end
      take();
      do_eret();
      n_checks++; if (irq_count !== 16'(i)) begin n_errors++; $display("FAIL b2b_count got %0d want %0d", irq_count, i); end
      n_checks++; if (s_irq_count !== ((i > 7) ? 3'd7 : 3'(i))) begin n_errors++; $display("FAIL sat_count got %0d want %0d", s_irq_count, (i > 7) ? 7 : i); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_withdraw();
    test_service_accum();
    test_held_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
